// File: rtl/pf_gpio_pkg.sv
// Shared constants and helpers for the pf_gpio_bank GPIO block.
// The legal ranges are WIDTH 1..GPIO_MAX_WIDTH and SYNC_STAGES GPIO_MIN_SYNC..GPIO_MAX_SYNC.
package pf_gpio_pkg;

   localparam int GPIO_MAX_WIDTH = 32;
   localparam int GPIO_MIN_SYNC  = 2;
   localparam int GPIO_MAX_SYNC  = 4;

   // The arming counter must be able to hold the value SYNC_STAGES+1.
   function automatic int arm_cnt_width(input int sync_stages);
      return $clog2(sync_stages + 2);
   endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// One GPIO channel's input path: synchroniser, edge detection and the
// sticky interrupt status flop.
import pf_gpio_pkg::*;

module gpio_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic pad_in,
   input  logic armed,
   input  logic irq_rise_en,
   input  logic irq_fall_en,
   input  logic irq_clr,
   output logic y,
   output logic rise,
   output logic fall,
   output logic irq_status
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   set;

   assign y    = sync_q[SYNC_STAGES-1];
   assign rise = armed &  y & ~prev_q;
   assign fall = armed & ~y &  prev_q;
   assign set  = (rise & irq_rise_en) | (fall & irq_fall_en);

   // NOTE: non-blocking assignments make every stage sample the previous
   // stage's old value, so the chain shifts by exactly one stage per clock.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q     <= '0;
         prev_q     <= 1'b0;
         irq_status <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
         prev_q <= y;
         // A new event must never be lost to a clear issued in the same cycle.
         if (set) begin
            irq_status <= 1'b1;
         end else if (irq_clr) begin
            irq_status <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pf_gpio_bank.sv
// Registered multi-channel bidirectional GPIO bank with synchronised input,
// edge detection and sticky maskable interrupts.
import pf_gpio_pkg::*;

module pf_gpio_bank #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] D,
   input  logic [WIDTH-1:0] E,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] RISE,
   output logic [WIDTH-1:0] FALL,
   input  logic [WIDTH-1:0] IRQ_RISE_EN,
   input  logic [WIDTH-1:0] IRQ_FALL_EN,
   input  logic [WIDTH-1:0] IRQ_CLR,
   output logic [WIDTH-1:0] IRQ_STATUS,
   output logic             IRQ,
   inout  wire  [WIDTH-1:0] PAD
);

   localparam int               ARM_W   = arm_cnt_width(SYNC_STAGES);
   localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);

   logic [ARM_W-1:0] arm_cnt;
   logic             armed;
   logic [WIDTH-1:0] d_q;
   logic [WIDTH-1:0] e_q;

   // Edges stay suppressed until the synchroniser and prev register hold
   // genuine post-reset pad samples.
   assign armed = (arm_cnt == ARM_MAX);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         arm_cnt <= '0;
         d_q     <= '0;
         e_q     <= '0;
      end else begin
         d_q <= D;
         e_q <= E;
         if (!armed) begin
            arm_cnt <= arm_cnt + 1'b1;
         end
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      assign PAD[i] = e_q[i] ? d_q[i] : 1'bz;

      gpio_sync_edge #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .clk         (CLK),
         .reset       (RESET),
         .pad_in      (PAD[i]),
         .armed       (armed),
         .irq_rise_en (IRQ_RISE_EN[i]),
         .irq_fall_en (IRQ_FALL_EN[i]),
         .irq_clr     (IRQ_CLR[i]),
         .y           (Y[i]),
         .rise        (RISE[i]),
         .fall        (FALL[i]),
         .irq_status  (IRQ_STATUS[i])
      );
   end

   assign IRQ = |IRQ_STATUS;

endmodule

// File: tb/tb_pf_gpio_bank.sv
// Self-checking bench for pf_gpio_bank: directed steps followed by random
// traffic, all compared against a pad-history reference model.
module tb_pf_gpio_bank;

   localparam int W = 8;
   localparam int S = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] d, e, rise_en, fall_en, clr;
   logic [W-1:0] ext_val, ext_en;
   wire  [W-1:0] pad;
   logic [W-1:0] y, rise, fall, irq_status;
   logic         irq;

   int    total = 0;
   int    bad   = 0;
   string phase = "init";

   // Reference model: registered output path plus a history of sampled pad
   // values since the last reset; Y, prev and armed fall out of the history.
   logic [W-1:0] m_d, m_e, m_status;
   logic [W-1:0] hist[$];

   always #5 clk = ~clk;

   for (genvar i = 0; i < W; i++) begin : g_ext
      assign pad[i] = ext_en[i] ? ext_val[i] : 1'bz;
   end

   pf_gpio_bank #(
      .WIDTH       (W),
      .SYNC_STAGES (S)
   ) dut (
      .CLK         (clk),
      .RESET       (reset),
      .D           (d),
      .E           (e),
      .Y           (y),
      .RISE        (rise),
      .FALL        (fall),
      .IRQ_RISE_EN (rise_en),
      .IRQ_FALL_EN (fall_en),
      .IRQ_CLR     (clr),
      .IRQ_STATUS  (irq_status),
      .IRQ         (irq),
      .PAD         (pad)
   );

   function automatic logic [W-1:0] m_y();
      return (hist.size() >= S) ? hist[hist.size() - S] : '0;
   endfunction

   function automatic logic [W-1:0] m_prev();
      return (hist.size() >= S + 1) ? hist[hist.size() - S - 1] : '0;
   endfunction

   function automatic logic m_armed();
      return hist.size() >= S + 1;
   endfunction

   function automatic logic [W-1:0] m_rise();
      return m_armed() ? (m_y() & ~m_prev()) : '0;
   endfunction

   function automatic logic [W-1:0] m_fall();
      return m_armed() ? (~m_y() & m_prev()) : '0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("pad",    32'(pad),        32'((m_e & m_d) | (~m_e & ext_val)));
      check("y",      32'(y),          32'(m_y()));
      check("rise",   32'(rise),       32'(m_rise()));
      check("fall",   32'(fall),       32'(m_fall()));
      check("status", 32'(irq_status), 32'(m_status));
      check("irq",    32'(irq),        32'(|m_status));
      check("excl",   32'(rise & fall), 32'(0));
   endtask

   // One clock: advance the model from the inputs present at the edge, hand
   // the pads the DUT no longer drives to the external driver, then compare.
   task automatic tick();
      logic [W-1:0] pad_now, set_v;
      pad_now = (m_e & m_d) | (~m_e & ext_val);
      set_v   = (m_rise() & rise_en) | (m_fall() & fall_en);
      @(posedge clk);
      if (reset) begin
         m_d      = '0;
         m_e      = '0;
         m_status = '0;
         hist.delete();
      end else begin
         m_status = set_v | (m_status & ~clr);
         hist.push_back(pad_now);
         if (hist.size() > S + 1) void'(hist.pop_front());
         m_d = d;
         m_e = e;
      end
      #1 ext_en = ~m_e;
      @(negedge clk);
      check_all();
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      reset   = 1'b1;
      d       = '0;
      e       = '0;
      rise_en = '0;
      fall_en = '0;
      clr     = '0;
      ext_val = 8'hFF;
      ext_en  = 8'hFF;
      m_d     = '0;
      m_e     = '0;
      m_status = '0;

      // Pads pulled high through reset: no spurious RISE after release.
      phase = "reset_pulled";
      ticks(3);
      reset = 1'b0;
      ticks(5);
      check("s1_y_high", 32'(y), 32'h0000_00FF);
      check("s1_status", 32'(irq_status), 32'h0);

      // Loopback from a low pad level, then random loopback values.
      phase = "loopback";
      ext_val = 8'h00;
      ticks(4);
      d = 8'hA5;
      e = 8'hFF;
      ticks(4);
      check("s2_y_a5", 32'(y), 32'h0000_00A5);
      for (int k = 0; k < 6; k++) begin
         d = 8'($urandom);
         ticks(3);
      end

      // Externally driven pad 3 with only its rise interrupt enabled.
      phase = "ext_rise";
      e       = '0;
      ext_val = 8'h00;
      rise_en = 8'h08;
      ticks(4);
      ext_val = 8'h08;
      ticks(5);
      ext_val = 8'h00;
      ticks(5);
      check("s3_irq", 32'(irq), 32'h1);

      // Clear collides with a new enabled rising edge: set wins.
      phase = "clr_collide";
      ext_val = 8'h08;
      ticks(2);
      check("s4_rise3", 32'(rise[3]), 32'h1);
      clr = 8'h08;
      tick();
      check("s4_kept", 32'(irq_status[3]), 32'h1);
      clr = 8'h00;
      tick();
      clr = 8'h08;
      tick();
      clr = 8'h00;
      check("s4_cleared", 32'(irq), 32'h0);

      // Reset in the middle of driving with pending status.
      phase = "mid_reset";
      ext_val = 8'h00;
      ticks(4);
      rise_en = 8'h0F;
      ext_val = 8'h0F;
      ticks(4);
      check("s5_status_0f", 32'(irq_status), 32'h0000_000F);
      rise_en = 8'h00;
      d = 8'h3C;
      e = 8'hFF;
      ticks(3);
      reset = 1'b1;
      tick();
      check("s5_y_zero", 32'(y), 32'h0);
      check("s5_status_zero", 32'(irq_status), 32'h0);
      reset = 1'b0;
      ticks(6);

      // All interrupts masked while every pad toggles.
      phase = "masked";
      rise_en = 8'h00;
      fall_en = 8'h00;
      e = 8'h00;
      for (int k = 0; k < 8; k++) begin
         ext_val = 8'($urandom);
         ticks(3);
         check("s6_irq_low", 32'(irq), 32'h0);
      end

      // Random traffic including occasional resets.
      phase = "random";
      for (int k = 0; k < 400; k++) begin
         reset   = ($urandom_range(0, 31) == 0);
         d       = 8'($urandom);
         e       = 8'($urandom);
         ext_val = 8'($urandom);
         rise_en = 8'($urandom);
         fall_en = 8'($urandom);
         clr     = 8'($urandom) & 8'($urandom) & 8'($urandom);
         tick();
      end
      reset = 1'b0;
      ticks(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
